// File: rtl/instr_fetch_if.sv
// instr_fetch_if
//   Bundles every signal between the fetch unit and its neighbours other than
//   clk/reset: the decode-side control inputs, the instruction-memory request
//   channel and the registered instruction presented to decode.
//   Ports (as seen by the fetch unit, modport master):
//     stall        in   decode cannot accept; hold presented instruction
//     flush        in   redirect; kill in-flight and presented instruction
//     redirect_pc  in   new fetch address, sampled when flush=1
//     imem_req     out  instruction memory request valid
//     imem_addr    out  word-aligned request address
//     imem_ack     in   response for the current request
//     imem_rdata   in   fetched instruction word
//     instr        out  registered instruction to decode
//     pc_out       out  registered address of instr
//     next_pc_out  out  registered pc_out + 4
//     valid_out    out  instr/pc_out/next_pc_out hold a live instruction
//   modport slave is the mirror image, used by the memory/decode environment.
interface instr_fetch_if;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] next_pc_out;
  logic        valid_out;

  modport master (
    input  stall, flush, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr, pc_out, next_pc_out, valid_out
  );

  modport slave (
    output stall, flush, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr, pc_out, next_pc_out, valid_out
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch
//   Single-outstanding-request instruction fetch stage. Issues word fetches to
//   instruction memory, presents one registered instruction per cycle to
//   decode, honours decode back-pressure (stall) and redirects (flush).
//   A one-entry buffer absorbs a response that arrives while decode stalls;
//   a response belonging to a request that was in flight when a flush hit is
//   waited for and dropped so the memory handshake is never abandoned.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous active-high reset
//     bus    instr_fetch_if.master  (memory request channel + decode side)
//   Parameter:
//     RESET_PC   first fetch address after reset
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  instr_fetch_if.master  bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // FETCH:   request outstanding at fetch_pc
  // HOLD:    response buffered while decode stalls; no request
  // DISCARD: request at a stale address still outstanding; its data is dropped
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] stale_addr_reg, stale_addr_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] npc_reg, npc_next;
  logic        valid_reg, valid_next;

  // Request lines come straight from state so the address is stable for the
  // whole life of a request; reset forces the request low immediately.
  assign bus.imem_req    = ~reset & (state_reg != HOLD);
  assign bus.imem_addr   = (state_reg == DISCARD) ? stale_addr_reg : fetch_pc_reg;
  assign bus.instr       = instr_reg;
  assign bus.pc_out      = pc_reg;
  assign bus.next_pc_out = npc_reg;
  assign bus.valid_out   = valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= FETCH;
      fetch_pc_reg   <= RESET_PC;
      stale_addr_reg <= 32'h0;
      buf_instr_reg  <= 32'h0;
      buf_pc_reg     <= 32'h0;
      instr_reg      <= NOP;
      pc_reg         <= 32'h0;
      npc_reg        <= 32'h0;
      valid_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      stale_addr_reg <= stale_addr_next;
      buf_instr_reg  <= buf_instr_next;
      buf_pc_reg     <= buf_pc_next;
      instr_reg      <= instr_next;
      pc_reg         <= pc_next;
      npc_reg        <= npc_next;
      valid_reg      <= valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    stale_addr_next = stale_addr_reg;
    buf_instr_next  = buf_instr_reg;
    buf_pc_next     = buf_pc_reg;
    instr_next      = instr_reg;
    pc_next         = pc_reg;
    npc_next        = npc_reg;
    valid_next      = valid_reg;

    // A redirect wins over stall and ack in every state: kill what decode
    // sees, drop any buffered response and restart at redirect_pc.
    if (bus.flush) begin
      valid_next     = 1'b0;
      instr_next     = NOP;
      fetch_pc_next  = bus.redirect_pc;
      buf_instr_next = 32'h0;
      buf_pc_next    = 32'h0;
    end

    case (state_reg)
      FETCH: begin
        if (bus.flush) begin
          // Request still pending: keep presenting the old address until the
          // memory answers, then throw that answer away.
          if (!bus.imem_ack) begin
            stale_addr_next = fetch_pc_reg;
            state_next      = DISCARD;
          end
        end else if (bus.imem_ack) begin
          fetch_pc_next = fetch_pc_reg + 32'd4;
          if (bus.stall) begin
            buf_instr_next = bus.imem_rdata;
            buf_pc_next    = fetch_pc_reg;
            state_next     = HOLD;
          end else begin
            instr_next = bus.imem_rdata;
            pc_next    = fetch_pc_reg;
            npc_next   = fetch_pc_reg + 32'd4;
            valid_next = 1'b1;
          end
        end else if (!bus.stall) begin
          valid_next = 1'b0;
        end
      end
      HOLD: begin
        if (bus.flush) begin
          state_next = FETCH;
        end else if (!bus.stall) begin
          instr_next = buf_instr_reg;
          pc_next    = buf_pc_reg;
          npc_next   = buf_pc_reg + 32'd4;
          valid_next = 1'b1;
          state_next = FETCH;
        end
      end
      DISCARD: begin
        // A flush here only retargets fetch_pc (handled above); the stale
        // request must still complete before a new one can be issued.
        if (bus.imem_ack) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
//   Randomised bench for instr_fetch. The reference model is the program
//   order a fetch stage must deliver: starting at RESET_PC (or the latest
//   redirect target) the accepted instructions are consecutive words, each
//   carrying the memory contents of its address. The driver pushes that
//   expected address stream into a queue when it issues reset/flush; an
//   independent monitor pops an entry whenever decode accepts an instruction
//   and also checks the handshake and hold/kill rules every cycle.
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int accepted = 0;
  int idle_cycles = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_pushed;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic void restart_stream(input logic [31:0] start);
    exp_q.delete();
    exp_q.push_back(start);
    last_pushed = start;
  endfunction

  function automatic void top_up();
    while (exp_q.size() < 8) begin
      last_pushed = last_pushed + 32'd4;
      exp_q.push_back(last_pushed);
    end
  endfunction

  function automatic logic [31:0] pick_redirect();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return r & 32'h0000_03FC;
      1:       return 32'hFFFF_FFF0 | (r & 32'h0000_000C);
      default: return r & 32'hFFFF_FFFC;
    endcase
  endfunction

  // Called just after a rising edge; checks that reset acts without a clock
  // edge and that the first request after release is at RESET_PC.
  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    check("rst_req",   {31'b0, bus.imem_req}, 32'd0);
    check("rst_addr",  bus.imem_addr, RESET_PC);
    check("rst_instr", bus.instr, NOP);
    check("rst_pc",    bus.pc_out, 32'd0);
    check("rst_npc",   bus.next_pc_out, 32'd0);
    check("rst_valid", {31'b0, bus.valid_out}, 32'd0);
    repeat (cycles) @(posedge clk);
    #2;
    reset = 1'b0;
    restart_stream(RESET_PC);
    top_up();
    #1;
    check("rel_req",  {31'b0, bus.imem_req}, 32'd1);
    check("rel_addr", bus.imem_addr, RESET_PC);
  endtask

  // Driver
  initial begin
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    #2;
    apply_reset(2);

    // Continuous ack, no stall: valid from the edge after the first ack.
    for (int c = 0; c < 8; c++) begin
      bus.imem_ack = 1'b1;
      bus.imem_rdata = mem_word(bus.imem_addr);
      top_up();
      @(negedge clk);
      check("cont_valid", {31'b0, bus.valid_out}, (c > 0) ? 32'd1 : 32'd0);
      if (c > 0) check("cont_pc", bus.pc_out, RESET_PC + 32'(4 * (c - 1)));
      @(posedge clk);
      #2;
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) apply_reset(2);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = pick_redirect();
      if (bus.imem_req) begin
        bus.imem_ack = ($urandom_range(0, 2) != 0);
        bus.imem_rdata = mem_word(bus.imem_addr);
      end else begin
        bus.imem_ack = ($urandom_range(0, 7) == 0);
        bus.imem_rdata = $urandom;
      end
      if (bus.flush) restart_stream(bus.redirect_pc);
      top_up();
      @(posedge clk);
      #2;
    end

    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (accepted >= 300) passes++;
    else $display("FAIL throughput: got %0d accepted instructions required at least 300", accepted);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Monitor: samples on the falling edge, when inputs and outputs are stable.
  logic        p_ok = 1'b0;
  logic        p_req, p_ack, p_stall, p_flush, p_valid;
  logic [31:0] p_addr, p_instr, p_pc, p_npc;

  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      p_ok = 1'b0;
      idle_cycles = 0;
    end else begin
      if (bus.imem_req) check("addr_align", bus.imem_addr & 32'h3, 32'h0);
      if (p_ok && p_req && !p_ack) begin
        check("req_hold",  {31'b0, bus.imem_req}, 32'd1);
        check("addr_hold", bus.imem_addr, p_addr);
      end
      if (p_ok && p_flush) begin
        check("flush_valid", {31'b0, bus.valid_out}, 32'd0);
        check("flush_instr", bus.instr, NOP);
      end else if (p_ok && p_stall) begin
        check("stall_valid", {31'b0, bus.valid_out}, {31'b0, p_valid});
        check("stall_instr", bus.instr, p_instr);
        check("stall_pc",    bus.pc_out, p_pc);
        check("stall_npc",   bus.next_pc_out, p_npc);
      end
      if (bus.valid_out && !bus.stall && !bus.flush) begin
        if (exp_q.size() == 0) begin
          check("sb_pending", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("seq_pc",    bus.pc_out, e);
          check("seq_instr", bus.instr, mem_word(e));
          check("seq_npc",   bus.next_pc_out, e + 32'd4);
          accepted++;
          $display("accept pc=%h instr=%h next_pc=%h", bus.pc_out, bus.instr, bus.next_pc_out);
        end
        idle_cycles = 0;
      end else begin
        idle_cycles++;
      end
      if (idle_cycles > 100) begin
        check("liveness", 32'(idle_cycles), 32'd100);
        idle_cycles = 0;
      end
      p_ok    = 1'b1;
      p_req   = bus.imem_req;
      p_ack   = bus.imem_ack;
      p_stall = bus.stall;
      p_flush = bus.flush;
      p_valid = bus.valid_out;
      p_addr  = bus.imem_addr;
      p_instr = bus.instr;
      p_pc    = bus.pc_out;
      p_npc   = bus.next_pc_out;
    end
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, first fetch address after reset.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: stall  in  1  decode stage cannot accept; hold outputs.
REQ-005 Port: flush  in  1  redirect; kill in-flight and presented instruction.
REQ-006 Port: redirect_pc  in  32  new fetch address, sampled when flush=1.
REQ-007 Port: imem_req  out  1  instruction memory request valid.
REQ-008 Port: imem_addr  out  32  request address; word-aligned.
REQ-009 Port: imem_ack  in  1  response for the current request; imem_rdata valid.
REQ-010 Port: imem_rdata  in  32  fetched instruction word.
REQ-011 Port: instr  out  32  registered instruction to decode.
REQ-012 Port: pc_out  out  32  registered address of instr.
REQ-013 Port: next_pc_out  out  32  registered pc_out+4.
REQ-014 Port: valid_out  out  1  instr/pc_out/next_pc_out hold a live instruction.

Function
REQ-015 At most one outstanding request; once imem_req=1, imem_req and imem_addr SHALL stay stable until a cycle with imem_ack=1.
REQ-016 Handshake completes on a rising edge with imem_req=1 and imem_ack=1; imem_ack while imem_req=0 SHALL be ignored.
REQ-017 State machine: FETCH (req=1, addr=fetch_pc), HOLD (req=0, response buffered), DISCARD (req=1, addr=stale address, response to be dropped).
REQ-018 FETCH, ack, no stall, no flush: outputs load instr=imem_rdata, pc_out=fetch_pc, next_pc_out=fetch_pc+4, valid_out=1; fetch_pc+=4; stay FETCH (one instruction per cycle when ack is continuous).
REQ-019 FETCH, no ack, no stall, no flush: valid_out<=0 (bubble); other outputs and fetch_pc unchanged.
REQ-020 FETCH, ack, stall=1, no flush: imem_rdata and fetch_pc SHALL be captured in a one-entry buffer; fetch_pc+=4; go to HOLD; outputs unchanged.
REQ-021 HOLD, stall=1: remain; outputs unchanged. HOLD, stall=0: buffer loads to outputs with valid_out=1; go to FETCH; the next request is issued in the following cycle.
REQ-022 Any stall=1 cycle without flush SHALL leave instr, pc_out, next_pc_out and valid_out unchanged.
REQ-023 flush=1 SHALL take priority over stall and ack: valid_out<=0, instr<=32'h00000013, fetch_pc<=redirect_pc, and the HOLD buffer is dropped.
REQ-024 flush while a request is pending without ack: latch the stale address and go to DISCARD; imem_addr SHALL remain at the stale address.
REQ-025 flush coinciding with ack, or flush in HOLD: go to FETCH; the next request is issued at redirect_pc.
REQ-026 DISCARD, ack: drop the response; go to FETCH. DISCARD, flush: update fetch_pc only and stay in DISCARD.
REQ-027 PC arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 SHALL wrap to 32'h00000000.
REQ-028 No fetch-to-output path is combinational; imem_req and imem_addr SHALL depend only on state and reset.

Reset
REQ-029 While reset=1: imem_req=0, imem_addr=RESET_PC, instr=32'h00000013, pc_out=0, next_pc_out=0, valid_out=0, state=FETCH, fetch_pc=RESET_PC, buffer cleared; takes effect immediately, without waiting for a clock edge.
REQ-030 Reset asserted mid-request SHALL abandon the request; the first request after reset release is at RESET_PC.

Verification
REQ-031 RESET_PC=0, ack every cycle, stall=0 -> valid_out=1 from the edge after the first ack; pc_out 0,4,8,...; next_pc_out=pc_out+4; instr equals the rdata for each address.
REQ-032 Request at 0x4 with ack delayed 3 cycles -> imem_addr=0x4 and imem_req=1 for all 3 cycles; valid_out=0 during the wait; then pc_out=0x4.
REQ-033 Ack for 0x8 arrives while stall=1 for 2 cycles -> outputs hold pc_out=0x4, imem_req=0; the cycle after stall falls, pc_out=0x8 with valid_out=1; the next request is to 0xC.
REQ-034 Request at 0x8 pending, flush with redirect_pc=0x100 -> imem_addr stays 0x8 until ack; the 0x8 response is never presented; the next request is 0x100; then pc_out=0x100.
REQ-035 flush, stall and ack in the same cycle, redirect_pc=0x40 -> valid_out=0, instr=32'h00000013, no HOLD; the next imem_addr=0x40.
REQ-036 reset pulse during an outstanding request -> all outputs take REQ-029 values immediately; after release, imem_addr=RESET_PC.
